// File: rtl/prog_boot_sequencer.sv
// Serial program loader: waits for a magic header on the program-UART byte stream,
// writes the payload words to memory while holding the core in reset, then releases it.
module prog_boot_sequencer #(
    parameter logic [31:0] MAGIC       = 32'h5352_4543,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned MAX_WORDS   = 65536
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_gnt_i,
    output logic        core_rst_o,
    output logic        prog_mode_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR} state_t;

    state_t      state, state_n;
    logic [1:0]  m, m_n;
    logic [2:0]  hdr_cnt, hdr_cnt_n;
    logic [55:0] hdr, hdr_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] addr, addr_n;
    logic [31:0] remaining, remaining_n;
    logic [31:0] wdata, wdata_n;
    logic [7:0]  csum, csum_n;
    logic [31:0] idle_cnt, idle_n;
    logic        skid_valid, skid_valid_n;
    logic [7:0]  skid_data, skid_data_n;

    logic [7:0]  magic_byte;
    logic [63:0] next_hdr;
    logic        take_valid;
    logic [7:0]  take_byte;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            m          <= '0;
            hdr_cnt    <= '0;
            hdr        <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            remaining  <= '0;
            wdata      <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            state      <= state_n;
            m          <= m_n;
            hdr_cnt    <= hdr_cnt_n;
            hdr        <= hdr_n;
            byte_cnt   <= byte_cnt_n;
            addr       <= addr_n;
            remaining  <= remaining_n;
            wdata      <= wdata_n;
            csum       <= csum_n;
            idle_cnt   <= idle_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        m_n          = m;
        hdr_cnt_n    = hdr_cnt;
        hdr_n        = hdr;
        byte_cnt_n   = byte_cnt;
        addr_n       = addr;
        remaining_n  = remaining;
        wdata_n      = wdata;
        csum_n       = csum;
        idle_n       = idle_cnt;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        magic_byte   = MAGIC[{m, 3'b000} +: 8];
        next_hdr     = {rx_data_i, hdr};
        take_valid   = skid_valid | rx_valid_i;
        take_byte    = skid_valid ? skid_data : rx_data_i;

        if (rx_valid_i)
            idle_n = '0;
        else if (state inside {HDR, DATA, CSUM})
            idle_n = idle_cnt + 32'd1;

        case (state)
            IDLE, ERR: begin
                if (rx_valid_i) begin
                    if (rx_data_i == magic_byte) begin
                        if (m == 2'd3) begin
                            state_n      = HDR;
                            m_n          = '0;
                            hdr_cnt_n    = '0;
                            byte_cnt_n   = '0;
                            csum_n       = '0;
                            skid_valid_n = 1'b0;
                        end else begin
                            m_n = m + 2'd1;
                        end
                    end else begin
                        m_n = (rx_data_i == MAGIC[7:0]) ? 2'd1 : 2'd0;
                    end
                end
            end
            HDR: begin
                if (rx_valid_i) begin
                    hdr_n     = next_hdr[63:8];
                    hdr_cnt_n = hdr_cnt + 3'd1;
                    if (hdr_cnt == 3'd7) begin
                        if (next_hdr[1:0] != 2'b00 || next_hdr[63:32] > MAX_WORDS)
                            state_n = ERR;
                        else if (next_hdr[63:32] == 32'd0)
                            state_n = CSUM;
                        else begin
                            state_n     = DATA;
                            addr_n      = next_hdr[31:0];
                            remaining_n = next_hdr[63:32];
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid_i) begin
                    wdata_n    = {rx_data_i, wdata[31:8]};
                    csum_n     = csum ^ rx_data_i;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3)
                        state_n = WRITE;
                end
            end
            WRITE: begin
                // A byte landing in the grant cycle goes through the skid path and is consumed at once.
                if (rx_valid_i && skid_valid) begin
                    state_n = ERR;
                end else begin
                    if (rx_valid_i) begin
                        skid_valid_n = 1'b1;
                        skid_data_n  = rx_data_i;
                    end
                    if (mem_gnt_i) begin
                        addr_n       = addr + 32'd4;
                        remaining_n  = remaining - 32'd1;
                        skid_valid_n = 1'b0;
                        if (remaining != 32'd1) begin
                            state_n = DATA;
                            if (take_valid) begin
                                wdata_n    = {take_byte, wdata[31:8]};
                                csum_n     = csum ^ take_byte;
                                byte_cnt_n = 2'd1;
                                idle_n     = '0;
                            end
                        end else if (take_valid) begin
                            state_n = (take_byte == csum) ? DONE : ERR;
                        end else begin
                            state_n = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (rx_valid_i)
                    state_n = (rx_data_i == csum) ? DONE : ERR;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state inside {HDR, DATA, CSUM} && !rx_valid_i && idle_cnt == TIMEOUT_CYC - 1)
            state_n = ERR;
        if (!(state inside {IDLE, ERR}))
            m_n = '0;
    end

    assign mem_req_o   = (state == WRITE);
    assign mem_addr_o  = addr;
    assign mem_wdata_o = wdata;
    assign mem_wstrb_o = {4{mem_req_o}};
    assign core_rst_o  = state inside {HDR, DATA, WRITE, CSUM, ERR};
    assign prog_mode_o = state inside {HDR, DATA, WRITE, CSUM};
    assign done_o      = (state == DONE);
    assign err_o       = (state == ERR);

endmodule

// File: tb/tb_prog_boot_sequencer.sv
// Self-checking bench for prog_boot_sequencer: table-driven load sessions,
// write scoreboard, and hand-written stall/overrun/timeout/reset sequences.
`timescale 1ns/1ps
module tb_prog_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        gnt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        core_rst;
    logic        prog_mode;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int req_cycles = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [31:0] base;
        logic [31:0] count;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  csum_xor;
        bit          send_data;
        bit          exp_done;
        bit          exp_err;
    } vec_t;
    vec_t cases[6];

    prog_boot_sequencer #(.TIMEOUT_CYC(100)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb),
        .mem_gnt_i  (gnt),
        .core_rst_o (core_rst),
        .prog_mode_o(prog_mode),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: sampled mid-cycle, so the handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) req_cycles++;
            if (done) done_cnt++;
            if (mem_req && gnt) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                    chk("wr_strb", mem_wstrb, 4'hF);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_magic();
        logic [31:0] mg;
        mg = 32'h5352_4543;
        for (int i = 0; i < 4; i++) send_byte(mg[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [31:0] base, input logic [31:0] count);
        send_word(base);
        send_word(count);
    endtask

    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        c;
        int          d0;
        int          r0;
        int          nw;
        logic [31:0] a;
        logic [31:0] word;
        logic [7:0]  cs;

        cases[0] = '{32'h8000_0000, 32'd2,     32'h1122_3344, 32'hAABB_CCDD, 8'h00, 1'b1, 1'b1, 1'b0};
        cases[1] = '{32'h8000_0000, 32'd2,     32'h1122_3344, 32'hAABB_CCDD, 8'h45, 1'b1, 1'b0, 1'b1};
        cases[2] = '{32'h0000_0000, 32'd0,     32'h0,         32'h0,         8'h00, 1'b1, 1'b1, 1'b0};
        cases[3] = '{32'h0000_0002, 32'd1,     32'h0,         32'h0,         8'h00, 1'b0, 1'b0, 1'b1};
        cases[4] = '{32'h0000_1000, 32'd65537, 32'h0,         32'h0,         8'h00, 1'b0, 1'b0, 1'b1};
        cases[5] = '{32'hFFFF_FFFC, 32'd2,     32'hDEAD_BEEF, 32'h0102_0304, 8'h00, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; gnt = 1'b1;
        tick(3);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_core_rst", core_rst, 0);
        chk("rst_prog_mode", prog_mode, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick(2);
        chk("idle_core_rst", core_rst, 0);

        // Magic overlap: 43 43 45 52 53
        send_byte(8'h43); send_byte(8'h43); send_byte(8'h45); send_byte(8'h52);
        chk("ovl_before_last", prog_mode, 0);
        send_byte(8'h53);
        chk("ovl_prog_mode", prog_mode, 1);
        chk("ovl_core_rst", core_rst, 1);
        d0 = done_cnt;
        send_hdr(32'h0, 32'h0);
        send_byte(8'h00);
        tick(3);
        chk("ovl_done", done_cnt - d0, 1);
        chk("ovl_core_rst_rel", core_rst, 0);

        for (int i = 0; i < 6; i++) begin
            c  = cases[i];
            d0 = done_cnt;
            r0 = req_cycles;
            nw = 0;
            send_magic();
            chk("case_prog_mode", prog_mode, 1);
            chk("case_core_rst", core_rst, 1);
            chk("case_err_clear", err, 0);
            send_hdr(c.base, c.count);
            if (c.send_data) begin
                nw = (c.count < 2) ? int'(c.count) : 2;
                cs = '0;
                a  = c.base;
                for (int w = 0; w < nw; w++) begin
                    word = (w == 0) ? c.w0 : c.w1;
                    sb.push_back({a, word});
                    a  = a + 32'd4;
                    cs = cs ^ xor_word(word);
                    send_word(word);
                end
                send_byte(cs ^ c.csum_xor);
            end
            tick(3);
            chk("case_done", done_cnt - d0, c.exp_done);
            chk("case_err", err, c.exp_err);
            chk("case_core_rst_end", core_rst, c.exp_err);
            chk("case_prog_mode_end", prog_mode, 0);
            chk("case_req_cycles", req_cycles - r0, nw);
            chk("case_sb_empty", sb.size(), 0);
        end

        // Grant stall with one byte captured in the skid register
        gnt = 1'b0;
        d0 = done_cnt;
        send_magic();
        send_hdr(32'h0000_0100, 32'd2);
        sb.push_back({32'h0000_0100, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D);
        chk("stall_req", mem_req, 1);
        send_byte(8'h78);
        tick(20);
        chk("stall_err", err, 0);
        chk("stall_req_held", mem_req, 1);
        chk("stall_addr", mem_addr, 32'h0000_0100);
        chk("stall_wdata", mem_wdata, 32'hCAFE_F00D);
        sb.push_back({32'h0000_0104, 32'h1234_5678});
        gnt = 1'b1;
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(xor_word(32'hCAFE_F00D) ^ xor_word(32'h1234_5678));
        tick(3);
        chk("stall_done", done_cnt - d0, 1);
        chk("stall_err_end", err, 0);
        chk("stall_sb_empty", sb.size(), 0);

        // Two bytes during a stall overrun the skid
        gnt = 1'b0;
        send_magic();
        send_hdr(32'h0000_0200, 32'd1);
        send_word(32'h0BAD_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        tick(1);
        chk("ovr_err", err, 1);
        chk("ovr_core_rst", core_rst, 1);
        chk("ovr_req", mem_req, 0);
        chk("ovr_prog_mode", prog_mode, 0);
        gnt = 1'b1;

        // Idle timeout after three header bytes (TIMEOUT_CYC=100)
        send_magic();
        chk("to_err_clear", err, 0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        tick(99);
        chk("to_err_99", err, 0);
        tick(1);
        chk("to_err_100", err, 1);
        chk("to_core_rst", core_rst, 1);

        // Asynchronous reset while a write is pending
        gnt = 1'b0;
        send_magic();
        send_hdr(32'h0000_0300, 32'd1);
        send_word(32'h5555_AAAA);
        chk("ar_req_before", mem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_wdata", mem_wdata, 0);
        chk("ar_wstrb", mem_wstrb, 0);
        chk("ar_core_rst", core_rst, 0);
        chk("ar_prog_mode", prog_mode, 0);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        tick(2);
        rst = 1'b0;
        gnt = 1'b1;
        r0 = req_cycles;
        tick(5);
        chk("ar_no_req_after", req_cycles - r0, 0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
